if_id_pipe: RTL

IF_ID_PIPE -- requirements
Module: if_id_pipe

---
 rtl/mips_defs_pkg.sv | 61 ++++++
 rtl/if_id_pipe_main_decoder.sv | 75 +++++++
 rtl/if_id_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode constants, ALU codes, fetch FSM encoding and control bundle.
package mips_defs_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FN_W    = 6;
    localparam int unsigned ALU_W   = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic             reg_dst;
        logic             branch;
        logic             mem_read;
        logic             mem_to_reg;
        logic             mem_write;
        logic             alu_src;
        logic             reg_write;
        logic             jump;
        logic [ALU_W-1:0] alu_ctrl;
        logic             illegal;
    } ctrl_t;

    // ALU operation for a legal R-type funct field
    function automatic logic [ALU_W-1:0] funct_alu(input logic [FN_W-1:0] funct);
        logic [ALU_W-1:0] alu;
        alu = ALU_AND;
        case (funct)
            FN_ADD:  alu = ALU_ADD;
            FN_SUB:  alu = ALU_SUB;
            FN_OR:   alu = ALU_OR;
            FN_SLT:  alu = ALU_SLT;
            default: alu = ALU_AND;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/if_id_pipe_main_decoder.sv
// Combinational main decoder: opcode/funct of the IF/ID word to datapath controls.
module main_decoder
    import mips_defs_pkg::*;
(
    input  logic             valid_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic [FN_W-1:0]  funct_i,
    output logic             reg_dst_o,
    output logic             branch_o,
    output logic             mem_read_o,
    output logic             mem_to_reg_o,
    output logic             mem_write_o,
    output logic             alu_src_o,
    output logic             reg_write_o,
    output logic             jump_o,
    output logic [ALU_W-1:0] alu_ctrl_o,
    output logic             illegal_o
);

    ctrl_t ctrl_c;

    // Decode table; an empty IF/ID slot yields all-zero controls
    always_comb begin
        ctrl_c = '0;
        if (valid_i) begin
            case (op_i)
                OP_RTYPE: begin
                    case (funct_i)
                        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                            ctrl_c.reg_dst   = 1'b1;
                            ctrl_c.reg_write = 1'b1;
                            ctrl_c.alu_ctrl  = funct_alu(funct_i);
                        end
                        default: ctrl_c.illegal = 1'b1;
                    endcase
                end
                OP_LW: begin
                    ctrl_c.mem_read   = 1'b1;
                    ctrl_c.mem_to_reg = 1'b1;
                    ctrl_c.alu_src    = 1'b1;
                    ctrl_c.reg_write  = 1'b1;
                    ctrl_c.alu_ctrl   = ALU_ADD;
                end
                OP_SW: begin
                    ctrl_c.mem_write = 1'b1;
                    ctrl_c.alu_src   = 1'b1;
                    ctrl_c.alu_ctrl  = ALU_ADD;
                end
                OP_BEQ: begin
                    ctrl_c.branch   = 1'b1;
                    ctrl_c.alu_ctrl = ALU_SUB;
                end
                OP_ADDI: begin
                    ctrl_c.alu_src   = 1'b1;
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.alu_ctrl  = ALU_ADD;
                end
                OP_J:    ctrl_c.jump    = 1'b1;
                default: ctrl_c.illegal = 1'b1;
            endcase
        end
    end

    assign reg_dst_o    = ctrl_c.reg_dst;
    assign branch_o     = ctrl_c.branch;
    assign mem_read_o   = ctrl_c.mem_read;
    assign mem_to_reg_o = ctrl_c.mem_to_reg;
    assign mem_write_o  = ctrl_c.mem_write;
    assign alu_src_o    = ctrl_c.alu_src;
    assign reg_write_o  = ctrl_c.reg_write;
    assign jump_o       = ctrl_c.jump;
    assign alu_ctrl_o   = ctrl_c.alu_ctrl;
    assign illegal_o    = ctrl_c.illegal;

endmodule

// File: rtl/if_id_pipe.sv
// Instruction fetch stage with PC, fetch FSM, stall/redirect handling and IF/ID register.
module if_id_pipe
    import mips_defs_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_en,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               imem_en_o,
    output logic [ADDR_W-3:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               id_valid_o,
    output logic [ADDR_W-1:0]  id_pc_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic               reg_dst_o,
    output logic               branch_o,
    output logic               mem_read_o,
    output logic               mem_to_reg_o,
    output logic               mem_write_o,
    output logic               alu_src_o,
    output logic               reg_write_o,
    output logic               jump_o,
    output logic [ALU_W-1:0]   alu_ctrl_o,
    output logic               illegal_o,
    output logic               misalign_o,
    output logic [CNT_W-1:0]   inst_cnt_o
);

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  fetch_pc_q;
    logic               fetch_live_q;
    logic               rvalid_q;
    logic               hold_full_q;
    logic [INSTR_W-1:0] hold_word_q;
    logic               id_valid_q;
    logic [ADDR_W-1:0]  id_pc_q;
    logic [INSTR_W-1:0] id_instr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               misalign_q;

    logic               advance_c;
    logic               redir_c;
    logic               fetch_c;
    logic [INSTR_W-1:0] cap_word_c;

    assign advance_c = step_en & ~stall_i;
    assign redir_c   = step_en & redirect_i;
    // A redirect cycle only loads the PC; the new target is fetched on the following advance
    assign fetch_c   = rst & advance_c & ~redirect_i;
    // Word returned while IF/ID was held is parked so it is never re-read from memory
    assign cap_word_c = hold_full_q ? hold_word_q : imem_rdata_i;

    // Next PC: aligned redirect target, sequential increment, or hold
    always_comb begin
        pc_d = pc_q;
        if (redir_c) begin
            pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
        end else if (fetch_c) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    // Fetch FSM, in-flight tracking, held-word buffer and IF/ID register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= '0;
            fetch_live_q <= 1'b0;
            rvalid_q     <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_word_q  <= '0;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_instr_q   <= '0;
            cnt_q        <= '0;
            misalign_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rvalid_q   <= fetch_c;
            misalign_q <= redir_c & (|redirect_pc_i[1:0]);
            if (redir_c) begin
                fetch_live_q <= 1'b0;
                hold_full_q  <= 1'b0;
                id_valid_q   <= 1'b0;
                state_q      <= ST_RUN;
            end else begin
                if (advance_c) begin
                    id_valid_q <= fetch_live_q;
                    if (fetch_live_q) begin
                        id_pc_q    <= fetch_pc_q;
                        id_instr_q <= cap_word_c;
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end
                    fetch_pc_q   <= pc_q;
                    fetch_live_q <= 1'b1;
                    hold_full_q  <= 1'b0;
                end else if (rvalid_q) begin
                    hold_word_q <= imem_rdata_i;
                    hold_full_q <= 1'b1;
                end
                case (state_q)
                    ST_BOOT: if (advance_c) state_q <= ST_RUN;
                    ST_RUN:  if (step_en && stall_i) state_q <= ST_HOLD;
                    ST_HOLD: if (!stall_i) state_q <= ST_RUN;
                    default: state_q <= ST_BOOT;
                endcase
            end
        end
    end

    assign imem_en_o   = fetch_c;
    assign imem_addr_o = pc_q[ADDR_W-1:2];
    assign id_valid_o  = id_valid_q;
    assign id_pc_o     = id_pc_q;
    assign id_instr_o  = id_instr_q;
    assign misalign_o  = misalign_q;
    assign inst_cnt_o  = cnt_q;

    main_decoder u_dec (
        .valid_i      (id_valid_q),
        .op_i         (id_instr_q[31:26]),
        .funct_i      (id_instr_q[5:0]),
        .reg_dst_o    (reg_dst_o),
        .branch_o     (branch_o),
        .mem_read_o   (mem_read_o),
        .mem_to_reg_o (mem_to_reg_o),
        .mem_write_o  (mem_write_o),
        .alu_src_o    (alu_src_o),
        .reg_write_o  (reg_write_o),
        .jump_o       (jump_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .illegal_o    (illegal_o)
    );

endmodule
